// File: rtl/md4_pkg.sv
// md4_pkg: shared constants and types for the sequential MD4 compression controller.
//   - IV words, per-round additive constants K
//   - per-round rotate amounts and the round-3 message word order
//   - controller FSM state enum and the step -> message word index helper
package md4_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StFinal, StDone} md4_state_e;

    localparam logic [31:0] IvA = 32'h67452301;
    localparam logic [31:0] IvB = 32'hefcdab89;
    localparam logic [31:0] IvC = 32'h98badcfe;
    localparam logic [31:0] IvD = 32'h10325476;

    localparam logic [31:0] RoundK [3] = '{32'h00000000, 32'h5A827999, 32'h6ED9EBA1};

    // Rotate amount per round, indexed by step % 4.
    localparam logic [4:0] ShiftTbl [3][4] = '{
        '{5'd3, 5'd7, 5'd11, 5'd19},
        '{5'd3, 5'd5, 5'd9,  5'd13},
        '{5'd3, 5'd9, 5'd11, 5'd15}
    };

    localparam logic [3:0] R2Idx [16] = '{
        4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
        4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15
    };

    // Message word used by step 0..47.
    function automatic logic [3:0] md4_word_idx(input logic [5:0] step);
        case (step[5:4])
            2'd0:    return step[3:0];
            2'd1:    return {step[1:0], step[3:2]};  // (i%4)*4 + (i%16)/4
            default: return R2Idx[step[3:0]];
        endcase
    endfunction

endpackage

// File: rtl/md4_iter_ctrl_if.sv
// md4_iter_ctrl_if: message-in / digest-out handshake bundle of md4_iter_ctrl.
//   msg_valid/msg_ready/msg_data (+ msg_first when MD4_MULTIBLOCK_EN is defined),
//   dig_valid/dig_ready/digest, busy.
//   slave modport = controller view, master modport = producer/consumer view.
interface md4_iter_ctrl_if;
    logic         msg_valid;
    logic         msg_ready;
    logic [511:0] msg_data;
`ifdef MD4_MULTIBLOCK_EN
    logic         msg_first;
`endif
    logic         dig_valid;
    logic         dig_ready;
    logic [127:0] digest;
    logic         busy;

`ifdef MD4_MULTIBLOCK_EN
    modport slave (
        input  msg_valid, msg_data, msg_first, dig_ready,
        output msg_ready, dig_valid, digest, busy
    );
    modport master (
        output msg_valid, msg_data, msg_first, dig_ready,
        input  msg_ready, dig_valid, digest, busy
    );
`else
    modport slave (
        input  msg_valid, msg_data, dig_ready,
        output msg_ready, dig_valid, digest, busy
    );
    modport master (
        output msg_valid, msg_data, dig_ready,
        input  msg_ready, dig_valid, digest, busy
    );
`endif
endinterface

// File: rtl/md4_step.sv
// md4_step: one combinational MD4 step, new = rotl(a + f(b,c,d) + x + K[round], s).
//   a_i..d_i  working words      x_i     message word
//   round_i   0=F, 1=G, 2=H      s_i     rotate amount
//   new_o     step result
module md4_step
    import md4_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] x_i,
    input  logic [1:0]  round_i,
    input  logic [4:0]  s_i,
    output logic [31:0] new_o
);
    logic [31:0] f;
    logic [31:0] k;
    logic [31:0] sum;

    always_comb begin
        f = b_i ^ c_i ^ d_i;
        k = RoundK[2];
        case (round_i)
            2'd0: begin
                f = (b_i & c_i) | (~b_i & d_i);
                k = RoundK[0];
            end
            2'd1: begin
                f = (b_i & c_i) | (b_i & d_i) | (c_i & d_i);
                k = RoundK[1];
            end
            default: ;
        endcase
        sum   = a_i + f + x_i + k;
        new_o = (sum << s_i) | (sum >> (6'd32 - {1'b0, s_i}));
    end

endmodule

// File: rtl/md4_iter_ctrl.sv
// md4_iter_ctrl: sequential MD4 compression, one step per clock over a shared md4_step.
//   clk, rst (async, active high)
//   md4_bus (slave): message handshake in, digest handshake out, busy.
// Optional feature macro MD4_MULTIBLOCK_EN: adds msg_first and chains blocks through the
// previous digest; without it every block hashes from the IV.
module md4_iter_ctrl
    import md4_pkg::*;
(
    input logic            clk,
    input logic            rst,
    md4_iter_ctrl_if.slave md4_bus
);
    md4_state_e   state_q, state_d;
    logic [5:0]   step_q, step_d;
    logic [511:0] msg_q, msg_d;
    logic [31:0]  a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic [31:0]  ch_a_q, ch_b_q, ch_c_q, ch_d_q, ch_a_d, ch_b_d, ch_c_d, ch_d_d;
    logic [127:0] digest_q, digest_d;

    logic [1:0]   round;
    logic [3:0]   word_idx;
    logic [31:0]  step_x;
    logic [31:0]  step_new;
    logic [31:0]  sum_a, sum_b, sum_c, sum_d;

    // step_q reaches 48 in FINAL; clamp so the table lookup stays in range.
    assign round    = (step_q[5:4] == 2'd3) ? 2'd2 : step_q[5:4];
    assign word_idx = md4_word_idx(step_q);
    assign step_x   = msg_q[{word_idx, 5'd0} +: 32];

    md4_step u_step (
        .a_i    (a_q),
        .b_i    (b_q),
        .c_i    (c_q),
        .d_i    (d_q),
        .x_i    (step_x),
        .round_i(round),
        .s_i    (ShiftTbl[round][step_q[1:0]]),
        .new_o  (step_new)
    );

    assign sum_a = ch_a_q + a_q;
    assign sum_b = ch_b_q + b_q;
    assign sum_c = ch_c_q + c_q;
    assign sum_d = ch_d_q + d_q;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        msg_d    = msg_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        ch_a_d   = ch_a_q;
        ch_b_d   = ch_b_q;
        ch_c_d   = ch_c_q;
        ch_d_d   = ch_d_q;
        digest_d = digest_q;
        case (state_q)
            StIdle: begin
                if (md4_bus.msg_valid) begin
                    msg_d   = md4_bus.msg_data;
                    step_d  = 6'd0;
                    state_d = StRun;
                    a_d     = ch_a_q;
                    b_d     = ch_b_q;
                    c_d     = ch_c_q;
                    d_d     = ch_d_q;
`ifdef MD4_MULTIBLOCK_EN
                    if (md4_bus.msg_first) begin
                        ch_a_d = IvA;
                        ch_b_d = IvB;
                        ch_c_d = IvC;
                        ch_d_d = IvD;
                        a_d    = IvA;
                        b_d    = IvB;
                        c_d    = IvC;
                        d_d    = IvD;
                    end
`endif
                end
            end
            StRun: begin
                a_d    = d_q;
                b_d    = step_new;
                c_d    = b_q;
                d_d    = c_q;
                step_d = step_q + 6'd1;
                if (step_q == 6'd47) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                digest_d = {sum_d, sum_c, sum_b, sum_a};
`ifdef MD4_MULTIBLOCK_EN
                ch_a_d = sum_a;
                ch_b_d = sum_b;
                ch_c_d = sum_c;
                ch_d_d = sum_d;
`else
                ch_a_d = IvA;
                ch_b_d = IvB;
                ch_c_d = IvC;
                ch_d_d = IvD;
`endif
                state_d = StDone;
            end
            StDone: begin
                if (md4_bus.dig_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            step_q   <= 6'd0;
            msg_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            ch_a_q   <= IvA;
            ch_b_q   <= IvB;
            ch_c_q   <= IvC;
            ch_d_q   <= IvD;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            msg_q    <= msg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            ch_a_q   <= ch_a_d;
            ch_b_q   <= ch_b_d;
            ch_c_q   <= ch_c_d;
            ch_d_q   <= ch_d_d;
            digest_q <= digest_d;
        end
    end

    assign md4_bus.msg_ready = (state_q == StIdle);
    assign md4_bus.dig_valid = (state_q == StDone);
    assign md4_bus.busy      = (state_q == StRun) || (state_q == StFinal);
    assign md4_bus.digest    = digest_q;

endmodule
